ngc_modal_counter: RTL and testbench

NGC_MODAL_COUNTER -- requirements
Module: ngc_modal_counter

---
 rtl/ngc_modal_counter.sv | 133 +++++++++++++
 tb/tb_ngc_modal_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ngc_modal_counter.sv
// Modal up/down counter with prescaler, programmable bounds and step.
// Supports wrap, one-shot, ping-pong and saturate modes.
module ngc_modal_counter #(
    parameter int COUNT_WIDTH    = 8,
    parameter int STEP_WIDTH     = COUNT_WIDTH / 2,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      enb,
    input  logic                      dir,
    input  logic [1:0]                mode,
    input  logic [COUNT_WIDTH-1:0]    load_value,
    input  logic [COUNT_WIDTH-1:0]    count_from_value,
    input  logic [COUNT_WIDTH-1:0]    count_to_value,
    input  logic [STEP_WIDTH-1:0]     step_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale_value,
    output logic [COUNT_WIDTH-1:0]    count,
    output logic                      count_hit,
    output logic                      done,
    output logic                      dir_out,
    output logic                      cfg_err
);

    localparam int CW = COUNT_WIDTH;

    typedef enum logic [1:0] {
        M_WRAP     = 2'd0,
        M_ONESHOT  = 2'd1,
        M_PINGPONG = 2'd2,
        M_SAT      = 2'd3
    } mode_t;

    mode_t                     m;
    logic                      dir_reg;
    logic [PRESCALE_WIDTH-1:0] presc;
    logic                      run;
    logic                      pre_term;
    logic                      tick;
    logic                      at_bound;
    logic [CW-1:0]             lo;
    logic [CW-1:0]             hi;
    logic [CW:0]               step_ext;
    logic [CW:0]               count_ext;
    logic [CW:0]               sum;
    logic [CW:0]               diff;
    logic [CW-1:0]             up_nxt;
    logic [CW-1:0]             dn_nxt;
    logic [CW-1:0]             nxt;
    logic [CW-1:0]             bound;
    logic [CW-1:0]             load_clamped;
    logic                      step_up;
    logic                      hit_nxt;
    logic                      done_nxt;
    logic                      dir_nxt;

    assign m         = mode_t'(mode);
    assign lo        = count_from_value;
    assign hi        = count_to_value;
    assign cfg_err   = lo > hi;
    assign dir_out   = (m == M_PINGPONG) ? dir_reg : dir;
    assign run       = enb & ~done & ~cfg_err;
    assign pre_term  = presc == prescale_value;
    assign tick      = run & pre_term;
    assign at_bound  = dir_out ? (count == hi) : (count == lo);
    assign step_ext  = (CW+1)'(step_value);
    assign count_ext = {1'b0, count};
    assign sum       = count_ext + step_ext;
    assign diff      = count_ext - step_ext;
    assign up_nxt    = (sum >= {1'b0, hi}) ? hi : sum[CW-1:0];
    assign dn_nxt    = (count_ext < ({1'b0, lo} + step_ext)) ? lo : diff[CW-1:0];

    assign load_clamped = (load_value < lo) ? lo :
                          (load_value > hi) ? hi : load_value;

    always_comb begin
        step_up = dir_out;
        // Ping-pong sitting on its bound turns around on this tick
        if (m == M_PINGPONG && at_bound) begin
            step_up = ~dir_out;
        end
        nxt = step_up ? up_nxt : dn_nxt;
        if (count < lo) begin
            nxt = lo;
        end else if (count > hi) begin
            nxt = hi;
        end else if (at_bound && m == M_WRAP) begin
            nxt = dir_out ? lo : hi;
        end else if (at_bound && (m == M_SAT || m == M_ONESHOT)) begin
            nxt = count;
        end
        bound    = step_up ? hi : lo;
        hit_nxt  = (nxt == bound) && (nxt != count);
        done_nxt = (m == M_ONESHOT) && (nxt == bound);
        dir_nxt  = step_up;
        if (nxt == hi && step_up) begin
            dir_nxt = 1'b0;
        end else if (nxt == lo && !step_up) begin
            dir_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            count_hit <= 1'b0;
            done      <= 1'b0;
            presc     <= '0;
            dir_reg   <= 1'b1;
        end else if (load) begin
            count     <= cfg_err ? load_value : load_clamped;
            count_hit <= 1'b0;
            done      <= 1'b0;
            presc     <= '0;
            dir_reg   <= dir;
        end else begin
            count_hit <= 1'b0;
            if (run) begin
                presc <= pre_term ? '0 : presc + PRESCALE_WIDTH'(1);
            end
            if (tick) begin
                count     <= nxt;
                count_hit <= hit_nxt;
                done      <= done_nxt;
                if (m == M_PINGPONG) begin
                    dir_reg <= dir_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ngc_modal_counter.sv
// Scoreboard bench for ngc_modal_counter: stimulus pushes expected
// state per cycle, a monitor pops and compares after each rising edge.
module tb_ngc_modal_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       enb = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] load_value = '0;
    logic [7:0] lo = '0;
    logic [7:0] hi = '0;
    logic [7:0] step = '0;
    logic [7:0] ps = '0;
    logic [7:0] count;
    logic       count_hit;
    logic       done;
    logic       dir_out;
    logic       cfg_err;

    typedef struct {
        int  cnt;
        bit  hit;
        bit  dn;
        int  dout;
        bit  err;
        int  line;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   vec = 0;

    ngc_modal_counter #(
        .COUNT_WIDTH(8),
        .STEP_WIDTH(8),
        .PRESCALE_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .enb(enb),
        .dir(dir),
        .mode(mode),
        .load_value(load_value),
        .count_from_value(lo),
        .count_to_value(hi),
        .step_value(step),
        .prescale_value(ps),
        .count(count),
        .count_hit(count_hit),
        .done(done),
        .dir_out(dir_out),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic go(input int c, input bit h = 0, input bit d = 0,
                      input int dout = -1, input bit e = 0);
        exp_t x;
        x.cnt  = c;
        x.hit  = h;
        x.dn   = d;
        x.dout = dout;
        x.err  = e;
        x.line = vec;
        vec++;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        exp_t x;
        bit ok;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                ok = (int'(count) == x.cnt) && (count_hit == x.hit) &&
                     (done == x.dn) && (cfg_err == x.err) &&
                     (x.dout < 0 || int'(dir_out) == x.dout);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL vec%0d: got cnt=%0d hit=%0b done=%0b dir=%0b err=%0b want cnt=%0d hit=%0b done=%0b dir=%0d err=%0b",
                             x.line, count, count_hit, done, dir_out, cfg_err,
                             x.cnt, x.hit, x.dn, x.dout, x.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        // reset state, ping-pong direction register comes up as up
        rst = 1; mode = 2;
        go(0, 0, 0, 1);
        mode = 0; dir = 0;
        go(0, 0, 0, 0);
        // first tick after reset clamps up to LO without a pulse
        rst = 0; enb = 1; dir = 1; lo = 5; hi = 20; step = 3;
        go(5, 0, 0, 1);

        // wrap mode
        lo = 2; hi = 10; step = 3; ps = 0; load = 1; load_value = 2;
        go(2);
        load = 0;
        go(5); go(8); go(10, 1); go(2); go(5);
        step = 0;
        go(5);
        lo = 7; hi = 9;
        go(7);
        step = 3;
        go(9, 1);

        // one-shot down
        mode = 1; dir = 0; lo = 0; hi = 20; step = 7;
        load = 1; load_value = 20;
        go(20, 0, 0, 0);
        load = 0;
        go(13); go(6); go(0, 1, 1);
        repeat (5) go(0, 0, 1);
        load = 1; load_value = 15;
        go(15, 0, 0);
        load = 0;

        // ping-pong, dir input ignored after load
        mode = 2; dir = 1; lo = 0; hi = 6; step = 4;
        load = 1; load_value = 0;
        go(0, 0, 0, 1);
        load = 0; dir = 0;
        go(4, 0, 0, 1); go(6, 1, 0, 0); go(2, 0, 0, 0);
        go(0, 1, 0, 1); go(4, 0, 0, 1);

        // prescaler and saturate
        mode = 3; dir = 1; lo = 0; hi = 255; step = 100; ps = 2;
        load = 1; load_value = 0;
        go(0);
        load = 0;
        go(0); go(0); go(100);
        go(100);
        enb = 0;
        go(100); go(100);
        enb = 1;
        go(100); go(200);
        go(200); go(200); go(255, 1, 0, 1);
        repeat (6) go(255, 0, 0, 1);

        // priority and configuration error
        rst = 1; load = 1; load_value = 50;
        go(0);
        rst = 0; load = 1; load_value = 77; mode = 0; ps = 0; step = 1;
        go(77);
        load = 0;
        go(78);
        lo = 9; hi = 3;
        go(78, 0, 0, -1, 1); go(78, 0, 0, -1, 1);
        load = 1; load_value = 200;
        go(200, 0, 0, -1, 1);
        load = 0;
        go(200, 0, 0, -1, 1);
        lo = 0; hi = 100;
        go(100, 1);
        load = 1; load_value = 250;
        go(100);
        load = 0; lo = 40; hi = 60; load = 1; load_value = 10;
        go(40);
        load = 0; rst = 1;
        go(0);
        rst = 0;

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
